// File: rtl/alut_pkg.sv
// Shared definitions for the ALUT address checker: entry layout, FSM states, hash.
package alut_pkg;

  localparam int unsigned MAC_W        = 48;
  localparam int unsigned ENT_ADDR_LSB = 0;
  localparam int unsigned ENT_PORT_LSB = MAC_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_D_EVAL = 2'd2,
    ST_S_EVAL = 2'd3
  } alut_state_e;

  function automatic int unsigned alut_pw(input int unsigned num_ports);
    return unsigned'($clog2(num_ports));
  endfunction

  function automatic int unsigned alut_dw(input int unsigned num_ports, input int unsigned ts_w);
    return 1 + ts_w + alut_pw(num_ports) + MAC_W;
  endfunction

  function automatic int unsigned alut_ts_lsb(input int unsigned pw);
    return ENT_PORT_LSB + pw;
  endfunction

  function automatic int unsigned alut_valid_bit(input int unsigned pw, input int unsigned ts_w);
    return alut_ts_lsb(pw) + ts_w;
  endfunction

  // XOR-fold of the address into hash_w-bit chunks; shifting in zeros pads the top chunk.
  // The caller truncates the result to hash_w bits.
  function automatic logic [MAC_W-1:0] alut_hash(input logic [MAC_W-1:0] addr,
                                                 input int unsigned      hash_w);
    logic [MAC_W-1:0] mask;
    logic [MAC_W-1:0] h;
    mask = (48'd1 << hash_w) - 48'd1;
    h    = '0;
    for (int c = 0; c < MAC_W; c++) begin
      h = h ^ ((addr >> (c * hash_w)) & mask);
    end
    return h;
  endfunction

endpackage

// File: rtl/alut_age_cmp.sv
// Wrap-safe age compare: an entry is in-date when (curr - ts) mod 2**TS_W <= limit.
module alut_age_cmp #(
  parameter int unsigned TS_W = 32
) (
  input  logic [TS_W-1:0] curr_time_i,
  input  logic [TS_W-1:0] ts_i,
  input  logic [TS_W-1:0] age_limit_i,
  output logic            in_date_o
);

  logic [TS_W-1:0] elapsed;

  assign elapsed   = curr_time_i - ts_i;
  assign in_date_o = (elapsed <= age_limit_i);

endmodule

// File: rtl/alut_addr_checker_mp.sv
// ALUT address checker: resolves destination mask and learns source into an external sync RAM.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a command, latches inputs on cmd_valid
// ST_LOOKUP | read destination entry
// ST_D_EVAL | resolve d_port from destination entry, read source entry
// ST_S_EVAL | publish d_port, write source entry, track overwritten entry
module alut_addr_checker_mp
  import alut_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  parameter  int unsigned HASH_W    = 8,
  parameter  int unsigned TS_W      = 32,
  localparam int unsigned PW        = alut_pw(NUM_PORTS),
  localparam int unsigned DW        = alut_dw(NUM_PORTS, TS_W)
) (
  input  logic                 pclk,
  input  logic                 p_reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [47:0]          d_addr,
  input  logic [47:0]          s_addr,
  input  logic [PW-1:0]        s_port,
  input  logic [47:0]          mac_addr,
  input  logic [TS_W-1:0]      curr_time,
  input  logic [TS_W-1:0]      age_limit,
  input  logic                 learn_en,
  input  logic                 clear_reused,
  output logic [HASH_W-1:0]    mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic [NUM_PORTS:0]   d_port,
  output logic                 d_port_valid,
  output logic                 busy,
  output logic                 reused,
  output logic [47:0]          lst_inv_addr,
  output logic [PW-1:0]        lst_inv_port
);

  localparam int unsigned TS_LSB = alut_ts_lsb(PW);
  localparam int unsigned V_BIT  = alut_valid_bit(PW, TS_W);

  alut_state_e state_q, state_d;

  logic [47:0]      d_addr_q, s_addr_q;
  logic [PW-1:0]    s_port_q;
  logic [TS_W-1:0]  curr_time_q;
  logic             learn_en_q;

  logic [NUM_PORTS:0] d_port_q, d_port_d, d_port_calc;
  logic               reused_q, reused_d;
  logic [47:0]        lst_inv_addr_q, lst_inv_addr_d;
  logic [PW-1:0]      lst_inv_port_q, lst_inv_port_d;

  logic [HASH_W-1:0]    d_hash, s_hash;
  logic                 rd_valid, rd_in_date;
  logic [TS_W-1:0]      rd_ts;
  logic [PW-1:0]        rd_port;
  logic [47:0]          rd_addr;
  logic                 sport_ok, learn_ok;
  logic [NUM_PORTS-1:0] rd_port_oh, s_port_oh;

  assign d_hash = HASH_W'(alut_hash(d_addr_q, HASH_W));
  assign s_hash = HASH_W'(alut_hash(s_addr_q, HASH_W));

  assign rd_addr  = mem_rdata[ENT_ADDR_LSB +: 48];
  assign rd_port  = mem_rdata[ENT_PORT_LSB +: PW];
  assign rd_ts    = mem_rdata[TS_LSB +: TS_W];
  assign rd_valid = mem_rdata[V_BIT];

  assign sport_ok   = (32'(s_port_q) < NUM_PORTS);
  assign learn_ok   = learn_en_q & sport_ok;
  assign rd_port_oh = NUM_PORTS'(1) << rd_port;
  assign s_port_oh  = NUM_PORTS'(1) << s_port_q;

  assign mem_wdata    = {1'b1, curr_time_q, s_port_q, s_addr_q};
  assign d_port       = d_port_q;
  assign reused       = reused_q;
  assign lst_inv_addr = lst_inv_addr_q;
  assign lst_inv_port = lst_inv_port_q;

  alut_age_cmp #(.TS_W(TS_W)) u_age_cmp (
    .curr_time_i (curr_time_q),
    .ts_i        (rd_ts),
    .age_limit_i (age_limit),
    .in_date_o   (rd_in_date)
  );

  // Destination mask from the entry read for d_addr; own MAC wins, bad ingress floods.
  always_comb begin
    d_port_calc = {1'b0, {NUM_PORTS{1'b1}}};
    if (d_addr_q == mac_addr) begin
      d_port_calc = {1'b1, {NUM_PORTS{1'b0}}};
    end else if (!sport_ok) begin
      d_port_calc = {1'b0, {NUM_PORTS{1'b1}}};
    end else if (rd_valid && (rd_addr == d_addr_q) && rd_in_date) begin
      d_port_calc = {1'b0, rd_port_oh & ~s_port_oh};
    end else begin
      d_port_calc = {1'b0, ~s_port_oh};
    end
  end

  // Next state, RAM strobes and result/reuse tracking.
  always_comb begin
    state_d        = state_q;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    d_port_valid   = 1'b0;
    d_port_d       = d_port_q;
    reused_d       = clear_reused ? 1'b0 : reused_q;
    lst_inv_addr_d = lst_inv_addr_q;
    lst_inv_port_d = lst_inv_port_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        mem_rd   = 1'b1;
        mem_addr = d_hash;
        state_d  = ST_D_EVAL;
      end
      ST_D_EVAL: begin
        mem_rd   = 1'b1;
        mem_addr = s_hash;
        d_port_d = d_port_calc;
        state_d  = ST_S_EVAL;
      end
      ST_S_EVAL: begin
        d_port_valid = 1'b1;
        mem_addr     = s_hash;
        mem_wr       = learn_ok;
        // Overwriting a live entry of another address; setting beats a same-cycle clear.
        if (learn_ok && rd_valid && (rd_addr != s_addr_q)) begin
          reused_d       = 1'b1;
          lst_inv_addr_d = rd_addr;
          lst_inv_port_d = rd_port;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and reuse registers.
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state_q        <= ST_IDLE;
      d_port_q       <= {1'b0, {NUM_PORTS{1'b1}}};
      reused_q       <= 1'b0;
      lst_inv_addr_q <= '0;
      lst_inv_port_q <= '0;
    end else begin
      state_q        <= state_d;
      d_port_q       <= d_port_d;
      reused_q       <= reused_d;
      lst_inv_addr_q <= lst_inv_addr_d;
      lst_inv_port_q <= lst_inv_port_d;
    end
  end

  // Command capture; inputs are only sampled on acceptance so they may change while busy.
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      d_addr_q    <= '0;
      s_addr_q    <= '0;
      s_port_q    <= '0;
      curr_time_q <= '0;
      learn_en_q  <= 1'b0;
    end else if ((state_q == ST_IDLE) && cmd_valid) begin
      d_addr_q    <= d_addr;
      s_addr_q    <= s_addr;
      s_port_q    <= s_port;
      curr_time_q <= curr_time;
      learn_en_q  <= learn_en;
    end
  end

endmodule

// File: tb/tb_alut_addr_checker_mp.sv
// Self-checking bench for alut_addr_checker_mp with a sync-RAM model and a table-level reference.
module tb_alut_addr_checker_mp;

  localparam int NP = 4;
  localparam int HW = 8;
  localparam int TW = 32;
  localparam int PW = 2;
  localparam int DW = 1 + TW + PW + 48;
  localparam logic [47:0] MAC = 48'h0000_AABB_CCDD;

  logic              pclk = 1'b0;
  logic              p_reset;
  logic              cmd_valid, cmd_ready;
  logic [47:0]       d_addr, s_addr, mac_addr;
  logic [PW-1:0]     s_port;
  logic [TW-1:0]     curr_time, age_limit;
  logic              learn_en, clear_reused;
  logic [HW-1:0]     mem_addr;
  logic              mem_rd, mem_wr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
  logic [NP:0]       d_port;
  logic              d_port_valid, busy, reused;
  logic [47:0]       lst_inv_addr;
  logic [PW-1:0]     lst_inv_port;

  alut_addr_checker_mp #(.NUM_PORTS(NP), .HASH_W(HW), .TS_W(TW)) dut (
    .pclk(pclk), .p_reset(p_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .d_addr(d_addr), .s_addr(s_addr), .s_port(s_port), .mac_addr(mac_addr),
    .curr_time(curr_time), .age_limit(age_limit), .learn_en(learn_en),
    .clear_reused(clear_reused), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .d_port(d_port),
    .d_port_valid(d_port_valid), .busy(busy), .reused(reused),
    .lst_inv_addr(lst_inv_addr), .lst_inv_port(lst_inv_port)
  );

  always #5 pclk = ~pclk;

  // External RAM: one-cycle read latency.
  logic [DW-1:0] ram [256] = '{default: '0};
  int wr_count = 0;
  always @(posedge pclk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference model: a table of learned entries indexed by the byte-XOR of the address.
  typedef struct {
    bit          v;
    logic [47:0] a;
    logic [1:0]  p;
    logic [31:0] ts;
  } ent_t;
  ent_t ref_tab [256];

  logic [NP:0]   exp_dport;
  bit            exp_wr;
  logic [DW-1:0] exp_wdata;
  bit            exp_reused = 1'b0;
  logic [47:0]   exp_inv_a = '0;
  logic [1:0]    exp_inv_p = '0;

  function automatic int ref_idx(input logic [47:0] a);
    longint unsigned x;
    int r;
    x = 64'(a);
    r = 0;
    for (int k = 0; k < 6; k++) begin
      r = r ^ int'(x % 256);
      x = x / 256;
    end
    return r;
  endfunction

  task automatic model_cmd(input logic [47:0] d, input logic [47:0] s, input logic [1:0] sp,
                           input logic [31:0] t, input logic [31:0] age, input bit le,
                           input bit clr);
    int di, si;
    ent_t e;
    bit hit;
    logic [31:0] elapsed;
    di = ref_idx(d);
    si = ref_idx(s);
    e  = ref_tab[di];
    elapsed = t - e.ts;
    hit = e.v && (e.a == d) && (elapsed <= age);
    exp_dport = '0;
    if (d == MAC) exp_dport[NP] = 1'b1;
    else for (int i = 0; i < NP; i++)
      exp_dport[i] = (i != int'(sp)) && (!hit || i == int'(e.p));
    exp_wr    = le;
    exp_wdata = {1'b1, t, sp, s};
    if (clr) exp_reused = 1'b0;
    if (le) begin
      if (ref_tab[si].v && ref_tab[si].a != s) begin
        exp_reused = 1'b1;
        exp_inv_a  = ref_tab[si].a;
        exp_inv_p  = ref_tab[si].p;
      end
      ref_tab[si].v  = 1'b1;
      ref_tab[si].a  = s;
      ref_tab[si].p  = sp;
      ref_tab[si].ts = t;
    end
  endtask

  logic [NP:0]   obs_dport;
  logic          obs_dvalid, obs_wr, obs_reused;
  logic [DW-1:0] obs_wdata;
  logic [HW-1:0] obs_maddr;
  logic [47:0]   obs_inv_a;
  logic [1:0]    obs_inv_p;

  // Issue one command from IDLE (called #1 after a rising edge); clr_ph selects which of the
  // four command cycles carries clear_reused, noise scrambles the inputs while busy.
  task automatic run_cmd(input logic [47:0] d, input logic [47:0] s, input logic [1:0] sp,
                         input logic [31:0] t, input bit le, input int clr_ph, input bit noise);
    chk("ready_idle", 128'(cmd_ready), 128'(1));
    d_addr = d; s_addr = s; s_port = sp; curr_time = t; learn_en = le;
    cmd_valid = 1'b1;
    clear_reused = (clr_ph == 0);
    @(posedge pclk); #1;
    cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noise) begin
      d_addr = 48'({$urandom(), $urandom()});
      s_addr = 48'({$urandom(), $urandom()});
      s_port = 2'($urandom_range(0, 3));
      curr_time = $urandom();
      learn_en = ~le;
    end
    clear_reused = (clr_ph == 1);
    chk("busy_lookup", 128'(busy), 128'(1));
    chk("ready_lookup", 128'(cmd_ready), 128'(0));
    chk("rd_lookup", 128'(mem_rd), 128'(1));
    chk("addr_lookup", 128'(mem_addr), 128'(ref_idx(d)));
    @(posedge pclk); #1;
    clear_reused = (clr_ph == 2);
    chk("valid_deval", 128'(d_port_valid), 128'(0));
    chk("addr_deval", 128'(mem_addr), 128'(ref_idx(s)));
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    clear_reused = (clr_ph == 3);
    obs_dvalid = d_port_valid; obs_dport = d_port; obs_wr = mem_wr;
    obs_wdata = mem_wdata; obs_maddr = mem_addr;
    @(posedge pclk); #1;
    clear_reused = 1'b0;
    obs_reused = reused; obs_inv_a = lst_inv_addr; obs_inv_p = lst_inv_port;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dvalid"}, 128'(obs_dvalid), 128'(1));
    chk({tag, "_dport"}, 128'(obs_dport), 128'(exp_dport));
    chk({tag, "_wr"}, 128'(obs_wr), 128'(exp_wr));
    if (exp_wr) chk({tag, "_wdata"}, 128'(obs_wdata), 128'(exp_wdata));
    chk({tag, "_reused"}, 128'(obs_reused), 128'(exp_reused));
    chk({tag, "_inv_addr"}, 128'(obs_inv_a), 128'(exp_inv_a));
    chk({tag, "_inv_port"}, 128'(obs_inv_p), 128'(exp_inv_p));
  endtask

  typedef struct {
    logic [47:0] d, s;
    logic [1:0]  sp;
    logic [31:0] t, age;
    bit          le;
    logic [4:0]  exp_dp;
    bit          exp_wr;
    logic [7:0]  exp_ma;
  } vec_t;

  localparam logic [47:0] A = 48'h0000_0000_1234;  // idx 26
  localparam logic [47:0] B = 48'h0000_0000_5678;  // idx 2E, never learned before row 9
  localparam logic [47:0] X = 48'h0000_0000_0102;  // idx 03
  localparam logic [47:0] Y = 48'h0000_0000_0304;  // idx 07
  localparam logic [47:0] Z = 48'h0011_2233_4455;  // idx 11
  localparam logic [47:0] W = 48'h0000_0000_0509;  // idx 0C
  localparam logic [47:0] P = 48'h0000_0000_0A0B;  // idx 01
  localparam logic [47:0] Q = 48'h0000_0000_0B0A;  // idx 01

  vec_t vecs [10];
  logic [47:0] pool [10];
  logic [31:0] t_now;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{MAC, A, 2'd0, 32'd10,  32'd50, 1'b1, 5'b1_0000, 1'b1, 8'h26};
    vecs[1] = '{B,   Z, 2'd1, 32'd20,  32'd50, 1'b1, 5'b0_1101, 1'b1, 8'h11};
    vecs[2] = '{B,   X, 2'd2, 32'd100, 32'd50, 1'b1, 5'b0_1011, 1'b1, 8'h03};
    vecs[3] = '{X,   Y, 2'd0, 32'd150, 32'd50, 1'b1, 5'b0_0100, 1'b1, 8'h07};
    vecs[4] = '{X,   Y, 2'd0, 32'd151, 32'd50, 1'b1, 5'b0_1110, 1'b1, 8'h07};
    vecs[5] = '{X,   Y, 2'd2, 32'd120, 32'd50, 1'b1, 5'b0_0000, 1'b1, 8'h07};
    vecs[6] = '{B,   W, 2'd3, 32'hFFFF_FFF0, 32'h20, 1'b1, 5'b0_0111, 1'b1, 8'h0C};
    vecs[7] = '{W,   A, 2'd1, 32'h10,  32'h20, 1'b1, 5'b0_1000, 1'b1, 8'h26};
    vecs[8] = '{W,   B, 2'd0, 32'h10,  32'h20, 1'b0, 5'b0_1000, 1'b0, 8'h2E};
    vecs[9] = '{MAC, B, 2'd3, 32'h10,  32'h20, 1'b0, 5'b1_0000, 1'b0, 8'h2E};

    p_reset = 1'b1; cmd_valid = 1'b0; clear_reused = 1'b0; learn_en = 1'b0;
    d_addr = '0; s_addr = '0; s_port = '0; curr_time = '0;
    mac_addr = MAC; age_limit = 32'd50;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_dport", 128'(d_port), 128'(5'b0_1111));
    chk("rst_dvalid", 128'(d_port_valid), 128'(0));
    chk("rst_rd", 128'(mem_rd), 128'(0));
    chk("rst_wr", 128'(mem_wr), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_reused", 128'(reused), 128'(0));
    chk("rst_inv_addr", 128'(lst_inv_addr), 128'(0));
    chk("rst_inv_port", 128'(lst_inv_port), 128'(0));
    chk("rst_maddr", 128'(mem_addr), 128'(0));
    p_reset = 1'b0;
    @(posedge pclk); #1;

    // Directed vectors: own MAC, miss, hit, stale, filter, timestamp wrap, learn disabled.
    for (int i = 0; i < 10; i++) begin
      age_limit = vecs[i].age;
      model_cmd(vecs[i].d, vecs[i].s, vecs[i].sp, vecs[i].t, vecs[i].age, vecs[i].le, 1'b0);
      run_cmd(vecs[i].d, vecs[i].s, vecs[i].sp, vecs[i].t, vecs[i].le, -1, 1'b0);
      chk($sformatf("vec%0d_dvalid", i), 128'(obs_dvalid), 128'(1));
      chk($sformatf("vec%0d_dport", i), 128'(obs_dport), 128'(vecs[i].exp_dp));
      chk($sformatf("vec%0d_wr", i), 128'(obs_wr), 128'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_maddr", i), 128'(obs_maddr), 128'(vecs[i].exp_ma));
      if (vecs[i].exp_wr) chk($sformatf("vec%0d_wdata", i), 128'(obs_wdata), 128'(exp_wdata));
      chk($sformatf("vec%0d_reused", i), 128'(obs_reused), 128'(0));
    end

    // Colliding learn: set and clear in the same cycle keeps reused set.
    age_limit = 32'd50;
    model_cmd(B, P, 2'd1, 32'd200, 32'd50, 1'b1, 1'b0);
    run_cmd(B, P, 2'd1, 32'd200, 1'b1, -1, 1'b0);
    check_model("coll_p");
    model_cmd(B, Q, 2'd2, 32'd210, 32'd50, 1'b1, 1'b1);
    run_cmd(B, Q, 2'd2, 32'd210, 1'b1, 3, 1'b0);
    chk("coll_reused", 128'(obs_reused), 128'(1));
    chk("coll_inv_addr", 128'(obs_inv_a), 128'(P));
    chk("coll_inv_port", 128'(obs_inv_p), 128'(1));
    chk("coll_dport", 128'(obs_dport), 128'(5'b0_1011));
    clear_reused = 1'b1;
    @(posedge pclk); #1;
    clear_reused = 1'b0;
    exp_reused = 1'b0;
    chk("clr_reused", 128'(reused), 128'(0));
    chk("clr_inv_addr", 128'(lst_inv_addr), 128'(P));
    chk("clr_inv_port", 128'(lst_inv_port), 128'(1));

    // Random traffic over a small pool with deliberate hash collisions.
    for (int i = 0; i < 5; i++) begin
      pool[i]     = 48'({$urandom(), $urandom()});
      pool[i + 5] = pool[i] ^ 48'h0101_0000_0000;
    end
    t_now = 32'd1000;
    for (int n = 0; n < 150; n++) begin
      logic [47:0] rd_d, rd_s;
      logic [1:0]  rsp;
      logic [31:0] rage;
      bit          rle;
      int          cph;
      rd_d = ($urandom_range(0, 9) == 0) ? MAC : pool[$urandom_range(0, 9)];
      rd_s = pool[$urandom_range(0, 9)];
      rsp  = 2'($urandom_range(0, 3));
      rage = 32'($urandom_range(0, 60));
      rle  = ($urandom_range(0, 4) != 0);
      cph  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      t_now = t_now + 32'($urandom_range(0, 30));
      age_limit = rage;
      model_cmd(rd_d, rd_s, rsp, t_now, rage, rle, cph >= 0);
      run_cmd(rd_d, rd_s, rsp, t_now, rle, cph, 1'b1);
      check_model($sformatf("rnd%0d", n));
      if ($urandom_range(0, 9) == 0) begin
        clear_reused = 1'b1;
        @(posedge pclk); #1;
        clear_reused = 1'b0;
        exp_reused = 1'b0;
        chk("rnd_idle_clr", 128'(reused), 128'(0));
      end
    end

    // Reset during D_EVAL aborts the command before its write.
    age_limit = 32'd50;
    d_addr = Y; s_addr = P; s_port = 2'd1; curr_time = t_now; learn_en = 1'b1;
    cmd_valid = 1'b1;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    chk("abort_in_deval", 128'(busy), 128'(1));
    p_reset = 1'b1;
    @(posedge pclk); #1;
    p_reset = 1'b0;
    chk("abort_ready", 128'(cmd_ready), 128'(1));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_dport", 128'(d_port), 128'(5'b0_1111));
    chk("abort_dvalid", 128'(d_port_valid), 128'(0));
    chk("abort_wr", 128'(mem_wr), 128'(0));
    chk("abort_reused", 128'(reused), 128'(0));
    chk("abort_inv_addr", 128'(lst_inv_addr), 128'(0));
    begin
      int w0;
      w0 = wr_count;
      repeat (3) @(posedge pclk);
      #1;
      chk("abort_no_write", 128'(wr_count), 128'(w0));
    end
    exp_reused = 1'b0; exp_inv_a = '0; exp_inv_p = '0;
    model_cmd(X, Z, 2'd3, t_now, 32'd50, 1'b1, 1'b0);
    run_cmd(X, Z, 2'd3, t_now, 1'b1, -1, 1'b0);
    check_model("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
